// File: rtl/seq_mul_fx.sv
// seq_mul_fx: iterative shift-add N x N -> 2N multiplier, K bits per cycle.
// Ports: clk, rst_n, in_valid/in_ready/a/b/is_signed in, out_valid/out_ready/p/q out, busy.
// Optional macro SEQ_MUL_ROUND_EN: round half-up and saturate the q output.
module seq_mul_fx #(
    parameter int N = 16,
    parameter int K = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic [N-1:0]   q,
    output logic           busy
);

    localparam int STEPS = N / K;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (N < 2 || (N % K) != 0) begin : g_bad_cfg
            $error("seq_mul_fx: need N >= 2 and N %% K == 0");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_nx;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           neg;
    logic           sgn;

    logic [N-1:0]   a_mag, b_mag;
    logic [2*N-1:0] pp, acc_nx, p_nx;
    logic [N-1:0]   q_nx;
    logic           last;

    // FSM next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = BUSY;
            end
            BUSY: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Magnitudes; -2^(N-1) maps onto 2^(N-1) as an unsigned N-bit value
    always_comb begin
        a_mag = (is_signed && a[N-1]) ? (~a + 1'b1) : a;
        b_mag = (is_signed && b[N-1]) ? (~b + 1'b1) : b;
    end

    // Partial products of the low K multiplier bits; mcand is pre-shifted
    always_comb begin
        pp = '0;
        for (int j = 0; j < K; j++) begin
            if (mplier[j]) pp = pp + (mcand << j);
        end
        acc_nx = acc + pp;
        p_nx   = neg ? (~acc_nx + 1'b1) : acc_nx;
        last   = (cnt == CW'(STEPS - 1));
    end

`ifdef SEQ_MUL_ROUND_EN
    logic [N+1:0] sq;

    // Signed field widened by two bits so the rounded value can be
    // range-checked before narrowing back to N bits
    always_comb begin
        sq = {p_nx[2*N-1], p_nx[2*N-1:N-1]} + (N+2)'(p_nx[N-2]);
        if (sgn) begin
            if (sq[N+1:N-1] == '0 || sq[N+1:N-1] == '1)
                q_nx = sq[N-1:0];
            else if (sq[N+1])
                q_nx = {1'b1, {(N-1){1'b0}}};
            else
                q_nx = {1'b0, {(N-1){1'b1}}};
        end else begin
            q_nx = p_nx[2*N-1:N] + N'(p_nx[N-1]);
        end
    end
`else
    always_comb begin
        q_nx = sgn ? p_nx[2*N-2:N-1] : p_nx[2*N-1:N];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            sgn    <= 1'b0;
            p      <= '0;
            q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{N{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= is_signed & (a[N-1] ^ b[N-1]);
                        sgn    <= is_signed;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << K;
                    mplier <= mplier >> K;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        p <= p_nx;
                        q <= q_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_fx.sv
// tb_seq_mul_fx: directed checks of seq_mul_fx at N=8 with K=1 and K=4.
// Each scenario task compares outputs against hand-computed products.
module tb_seq_mul_fx;

    localparam int N = 8;
`ifdef SEQ_MUL_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic           iv1 = 0, ir1, ov1, or1 = 0, s1 = 0, bz1;
    logic [N-1:0]   a1 = 0, b1 = 0, q1;
    logic [2*N-1:0] p1;

    logic           iv4 = 0, ir4, ov4, or4 = 0, s4 = 0, bz4;
    logic [N-1:0]   a4 = 0, b4 = 0, q4;
    logic [2*N-1:0] p4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mul_fx #(.N(N), .K(1)) u_k1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .is_signed(s1),
        .out_valid(ov1), .out_ready(or1), .p(p1), .q(q1), .busy(bz1)
    );

    seq_mul_fx #(.N(N), .K(4)) u_k4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .is_signed(s4),
        .out_valid(ov4), .out_ready(or4), .p(p4), .q(q4), .busy(bz4)
    );

    task automatic test_reset();
        checks++;
        if ({ir1, ov1, bz1} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags got %b want 100", {ir1, ov1, bz1});
        end
        checks++;
        if (p1 !== 16'h0 || q1 !== 8'h0) begin
            errors++;
            $display("FAIL reset_pq got p=%h q=%h want 0", p1, q1);
        end
        checks++;
        if ({ir4, ov4, bz4} !== 3'b100 || p4 !== 16'h0) begin
            errors++;
            $display("FAIL reset_k4 got %b p=%h", {ir4, ov4, bz4}, p4);
        end
    endtask

    // One K=1 transaction: accept, latency 8, product, release
    task automatic test_k1(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [15:0] ep, input logic [7:0] eq);
        int cyc;
        @(negedge clk);
        a1 = a; b1 = b; s1 = s; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        cyc = 0;
        while (!ov1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL %s_lat got %0d want 8", nm, cyc);
        end
        checks++;
        if (p1 !== ep) begin
            errors++;
            $display("FAIL %s_p got %h want %h", nm, p1, ep);
        end
        checks++;
        if (q1 !== eq) begin
            errors++;
            $display("FAIL %s_q got %h want %h", nm, q1, eq);
        end
        @(negedge clk);
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        checks++;
        if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_release got ov=%b ir=%b want 0 1", nm, ov1, ir1);
        end
    endtask

    task automatic test_k4();
        int cyc;
        @(negedge clk);
        a4 = 8'hFF; b4 = 8'hFF; s4 = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        cyc = 0;
        while (!ov4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL k4_lat got %0d want 2", cyc);
        end
        checks++;
        if (p4 !== 16'hFE01 || q4 !== 8'hFE) begin
            errors++;
            $display("FAIL k4_pq got p=%h q=%h want FE01 FE", p4, q4);
        end
        @(negedge clk);
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
        checks++;
        if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
            errors++;
            $display("FAIL k4_release got ov=%b ir=%b", ov4, ir4);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        a1 = 8'h03; b1 = 8'h04; s1 = 1'b0; iv1 = 1'b1;
        @(posedge clk); #1;
        a1 = 8'h10; b1 = 8'h10;
        cyc = 0;
        while (!ov1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL bp_lat got %0d want 8", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ov1 !== 1'b1 || ir1 !== 1'b0 || p1 !== 16'h000C || q1 !== 8'h00) begin
                errors++;
                $display("FAIL bp_hold%0d got ov=%b ir=%b p=%h q=%h", i, ov1, ir1, p1, q1);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        checks++;
        if (ov1 !== 1'b0 || ir1 !== 1'b1 || bz1 !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle got ov=%b ir=%b bz=%b", ov1, ir1, bz1);
        end
        @(posedge clk); #1;
        iv1 = 1'b0;
        checks++;
        if (bz1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept got busy=%b want 1", bz1);
        end
        cyc = 0;
        while (!ov1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 8 || p1 !== 16'h0100 || q1 !== 8'h01) begin
            errors++;
            $display("FAIL bp_next got lat=%0d p=%h q=%h want 8 0100 01", cyc, p1, q1);
        end
        @(negedge clk);
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a1 = 8'hAB; b1 = 8'hCD; s1 = 1'b0; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        repeat (3) begin
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bz1 !== 1'b0 || ov1 !== 1'b0 || ir1 !== 1'b1 || p1 !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid got bz=%b ov=%b ir=%b p=%h", bz1, ov1, ir1, p1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_k1("after_rst", 8'hFD, 8'hFD, 1'b1, 16'h0009, 8'h00);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_k1("u0F", 8'h0F, 8'h0F, 1'b0, 16'h00E1, RND ? 8'h01 : 8'h00);
        test_k1("uFFx2", 8'hFF, 8'h02, 1'b0, 16'h01FE, RND ? 8'h02 : 8'h01);
        test_k4();
        test_k1("sneg3", 8'hFD, 8'h05, 1'b1, 16'hFFF1, RND ? 8'h00 : 8'hFF);
        test_k1("sbneg", 8'h05, 8'hFD, 1'b1, 16'hFFF1, RND ? 8'h00 : 8'hFF);
        test_k1("s7F", 8'h7F, 8'h7F, 1'b1, 16'h3F01, 8'h7E);
        test_k1("s80", 8'h80, 8'h80, 1'b1, 16'h4000, RND ? 8'h7F : 8'h80);
        test_k1("u80", 8'h80, 8'h80, 1'b0, 16'h4000, 8'h40);
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
